store_queue: RTL

//  In-order store queue; SQ end of the ROB<->SQ store-commit handshake. Holds dispatched stores
//  in program order and captures address/data from the store FU. Drains the oldest store to the

---
 rtl/store_queue_if.sv | 23 ++
 rtl/store_queue.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/store_queue_if.sv
// store_queue_if: data-cache write channel between the store queue and the dcache.
//   mem_req_valid/addr/data/size : store write request, held stable until accepted
//   mem_req_ready                : dcache accepts the request this cycle
//   mem_resp_valid               : dcache reports the write as complete
// Modports: master = store queue side, slave = dcache side.
interface store_queue_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic [1:0]  mem_req_size;
  logic        mem_resp_valid;

  modport master (
    output mem_req_valid, mem_req_addr, mem_req_data, mem_req_size,
    input  mem_req_ready, mem_resp_valid
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_data, mem_req_size,
    output mem_req_ready, mem_resp_valid
  );
endinterface

// File: rtl/store_queue.sv
// store_queue: in-order store queue. Allocates dispatched stores in program order, captures
// address/data from the store FU, and writes the oldest store to the dcache once the ROB
// reports it committable, returning a one-cycle completion count to the ROB.
// Ports:
//   clock, reset            : clock, synchronous active-high reset
//   dp_valid, dp_mem_size   : per-lane dispatch (lanes packed from lane 0) and access size
//   fu_sq_valid/idx/addr/data : store FU result written into entry fu_sq_idx
//   rob_commit_insns_num    : committable stores at ROB head
//   squash                  : ROB flush
//   sq_tail_entries         : entry index handed to each dispatch lane
//   almost_full             : dispatch must stall
//   sq_sent_insns_num       : stores completed this cycle (combinational, 0 or 1)
//   mem                     : dcache write channel (store_queue_if.master)
// Optional feature: define SQ_FWD_EN to add store-to-load forwarding
//   (ld_valid, ld_addr, ld_sq_tail in; fwd_hit, fwd_data out, combinational).
module store_queue #(
  parameter int unsigned SIZE        = 8,
  parameter int unsigned N           = 3,
  parameter int unsigned ALERT_DEPTH = N,
  localparam int unsigned PTR_W      = $clog2(SIZE),
  localparam int unsigned IDX_W      = $clog2(SIZE) + 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N-1:0]            dp_valid,
  input  logic [N-1:0][1:0]       dp_mem_size,
  input  logic                    fu_sq_valid,
  input  logic [PTR_W-1:0]        fu_sq_idx,
  input  logic [31:0]             fu_sq_addr,
  input  logic [31:0]             fu_sq_data,
  input  logic [IDX_W-1:0]        rob_commit_insns_num,
  input  logic                    squash,
`ifdef SQ_FWD_EN
  input  logic                    ld_valid,
  input  logic [31:0]             ld_addr,
  input  logic [PTR_W-1:0]        ld_sq_tail,
  output logic                    fwd_hit,
  output logic [31:0]             fwd_data,
`endif
  output logic [N-1:0][PTR_W-1:0] sq_tail_entries,
  output logic                    almost_full,
  output logic [IDX_W-1:0]        sq_sent_insns_num,
  store_queue_if.master           mem
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t           state, state_n;
  logic [PTR_W-1:0] head, tail, head_n, tail_n;
  logic [IDX_W-1:0] count, count_n, dp_num;
  logic [SIZE-1:0]  filled;
  logic [31:0]      addr_q [SIZE];
  logic [31:0]      data_q [SIZE];
  logic [1:0]       size_q [SIZE];
  logic             dp_fire, complete, in_flight;

  // Dispatch slot assignment and accepted-store count
  always_comb begin : dispatch_ctrl
    almost_full = count > IDX_W'(SIZE - ALERT_DEPTH);
    dp_fire     = !almost_full && !squash;
    dp_num      = '0;
    for (int i = 0; i < int'(N); i++) begin
      sq_tail_entries[i] = tail + PTR_W'(i);
      if (dp_fire && dp_valid[i]) dp_num = dp_num + IDX_W'(1);
    end
  end

  // Drain FSM: one store in flight; a response together with ready completes from REQ
  always_comb begin : drain_fsm
    state_n            = state;
    complete           = 1'b0;
    in_flight          = (state == S_REQ) || (state == S_WAIT);
    mem.mem_req_valid  = 1'b0;
    mem.mem_req_addr   = addr_q[head];
    mem.mem_req_data   = data_q[head];
    mem.mem_req_size   = size_q[head];
    case (state)
      S_IDLE: begin
        // a same-cycle squash discards the head, so it must not launch
        if (count != '0 && rob_commit_insns_num != '0 && filled[head] && !squash)
          state_n = S_REQ;
      end
      S_REQ: begin
        mem.mem_req_valid = 1'b1;
        if (mem.mem_req_ready) begin
          complete = mem.mem_resp_valid;
          state_n  = mem.mem_resp_valid ? S_IDLE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem.mem_resp_valid) begin
          complete = 1'b1;
          state_n  = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
    sq_sent_insns_num = IDX_W'(complete);
  end

  // Pointer/occupancy update; completion is applied before squash truncation
  always_comb begin : ptr_update
    head_n = head + PTR_W'(complete);
    if (squash) begin
      if (in_flight && !complete) begin
        tail_n  = head + PTR_W'(1);
        count_n = IDX_W'(1);
      end else begin
        tail_n  = head_n;
        count_n = '0;
      end
    end else begin
      tail_n  = tail + PTR_W'(dp_num);
      count_n = count + dp_num - IDX_W'(complete);
    end
  end

  // Control state and per-entry filled flags
  always_ff @(posedge clock) begin : ctrl_regs
    if (reset) begin
      state  <= S_IDLE;
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      filled <= '0;
    end else begin
      state <= state_n;
      head  <= head_n;
      tail  <= tail_n;
      count <= count_n;
      for (int i = 0; i < int'(N); i++) begin
        if (dp_fire && dp_valid[i]) filled[sq_tail_entries[i]] <= 1'b0;
      end
      if (fu_sq_valid) filled[fu_sq_idx] <= 1'b1;
    end
  end

  // Entry payload storage (qualified by filled, so no reset needed)
  always_ff @(posedge clock) begin : entry_store
    for (int i = 0; i < int'(N); i++) begin
      if (dp_fire && dp_valid[i]) size_q[sq_tail_entries[i]] <= dp_mem_size[i];
    end
    if (fu_sq_valid) begin
      addr_q[fu_sq_idx] <= fu_sq_addr;
      data_q[fu_sq_idx] <= fu_sq_data;
    end
  end

`ifdef SQ_FWD_EN
  logic [IDX_W-1:0] ld_span;
  logic [PTR_W-1:0] probe;
  logic             fwd_stop;

  // Youngest-first search over stores older than the load; an unfilled store blocks it
  always_comb begin : fwd_search
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_stop = 1'b0;
    probe    = '0;
    ld_span  = {1'b0, PTR_W'(ld_sq_tail - head)};
    if (ld_span == '0 && count == IDX_W'(SIZE)) ld_span = IDX_W'(SIZE);
    for (int k = 0; k < int'(SIZE); k++) begin
      probe = ld_sq_tail - PTR_W'(k + 1);
      if (!reset && ld_valid && !fwd_stop && IDX_W'(k) < ld_span) begin
        if (!filled[probe]) begin
          fwd_stop = 1'b1;
        end else if (size_q[probe] == 2'd2 && addr_q[probe] == ld_addr) begin
          fwd_hit  = 1'b1;
          fwd_data = data_q[probe];
          fwd_stop = 1'b1;
        end
      end
    end
  end
`endif

endmodule
